// File: rtl/BasicTypes.sv
// Shared types for the load/store unit: FSM state enum, RISC-V load/store
// funct3 width codes and default MMIO addresses.
package BasicTypes;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StDrain,
      StResp
   } LsuState;

   localparam logic [2:0] Funct3B  = 3'b000;
   localparam logic [2:0] Funct3H  = 3'b001;
   localparam logic [2:0] Funct3W  = 3'b010;
   localparam logic [2:0] Funct3D  = 3'b011;
   localparam logic [2:0] Funct3BU = 3'b100;
   localparam logic [2:0] Funct3HU = 3'b101;
   localparam logic [2:0] Funct3WU = 3'b110;

   localparam logic [31:0] UartAddrDefault    = 32'hF000_0000;
   localparam logic [31:0] CounterAddrDefault = 32'hF000_0100;

endpackage

// File: rtl/load_data_aligner.sv
// Load data aligner: shifts the selected bytes of a full-width bus word down
// to bit 0 and zero- or sign-extends them to DATA_WIDTH. Purely combinational.
module load_data_aligner #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]           rdata_i,
   input  logic [$clog2(DATA_WIDTH/8)-1:0] offset_i,
   input  logic [2:0]                      funct3_i,
   output logic [DATA_WIDTH-1:0]           data_o
);

   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] mask;
   logic                  sign;

   // Shift requested bytes down, then mask and extend by access size.
   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      mask    = '1;
      sign    = 1'b0;
      case (funct3_i[1:0])
         2'd0: begin
            mask = DATA_WIDTH'(8'hFF);
            sign = shifted[7];
         end
         2'd1: begin
            mask = DATA_WIDTH'(16'hFFFF);
            sign = shifted[15];
         end
         2'd2: begin
            mask = DATA_WIDTH'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: begin
            mask = '1;
            sign = 1'b0;
         end
      endcase
      // funct3[2] marks the unsigned (zero-extending) variants
      data_o = (shifted & mask) | ((~funct3_i[2] & sign) ? ~mask : '0);
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request at a time. Bus loads/stores go
// through REQ/WAIT, a byte store to UART_ADDR and a load from COUNTER_ADDR are
// served locally without touching the bus.
// Build option: LSU_MISALIGN_TRAP_EN -- misaligned accesses complete with
// respFault=1 and no bus traffic; otherwise addresses are aligned down.
module load_store_unit
   import BasicTypes::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter logic [31:0] UART_ADDR    = UartAddrDefault,
   parameter logic [31:0] COUNTER_ADDR = CounterAddrDefault
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    reqValid,
   output logic                    reqReady,
   input  logic                    reqStore,
   input  logic [2:0]              reqFunct3,
   input  logic [ADDR_WIDTH-1:0]   reqAddr,
   input  logic [DATA_WIDTH-1:0]   reqWData,
   output logic                    respValid,
   output logic [DATA_WIDTH-1:0]   respData,
   output logic                    respFault,
   output logic                    memReqValid,
   input  logic                    memReqReady,
   output logic                    memWe,
   output logic [ADDR_WIDTH-1:0]   memAddr,
   output logic [DATA_WIDTH/8-1:0] memByteEn,
   output logic [DATA_WIDTH-1:0]   memWData,
   input  logic                    memRespValid,
   input  logic [DATA_WIDTH-1:0]   memRData,
   output logic [7:0]              uart,
   output logic                    uartWe
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned OffW     = $clog2(NumBytes);

   LsuState               state_q, state_d;
   logic                  store_q, store_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [OffW-1:0]       off_q, off_d;
   logic [NumBytes-1:0]   be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  fault_q, fault_d;
   logic [7:0]            uart_q, uart_d;
   logic                  uart_we_q, uart_we_d;
   logic [DATA_WIDTH-1:0] counter_q;

   logic                  too_wide;
   logic [1:0]            size_eff;
   logic [3:0]            nbytes;
   logic [ADDR_WIDTH-1:0] lo_mask;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [OffW-1:0]       req_off;
   logic [NumBytes-1:0]   be_base;
   logic [DATA_WIDTH-1:0] wmask;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  trap;
   logic                  accept;
   logic [DATA_WIDTH-1:0] load_data;

   // Decode the incoming request: access size, aligned address, lanes, data.
   always_comb begin
      // D and WU cannot be carried by a 32-bit path; treat as an oversized word
      too_wide = (DATA_WIDTH == 32) && ((reqFunct3[1:0] == 2'd3) || (reqFunct3 == Funct3WU));
      size_eff = too_wide ? 2'd2 : reqFunct3[1:0];
      nbytes   = 4'd1 << size_eff;
      lo_mask  = ADDR_WIDTH'(nbytes) - ADDR_WIDTH'(1);
      eff_addr = reqAddr & ~lo_mask;
      req_off  = eff_addr[OffW-1:0];
      be_base  = NumBytes'((9'd1 << nbytes) - 9'd1);
      wmask    = '0;
      for (int i = 0; i < NumBytes; i++) begin
         wmask[8*i +: 8] = {8{be_base[i]}};
      end
      // Bytes outside the access are zeroed so unused lanes carry no stale data
      req_wdata = (reqWData & wmask) << {req_off, 3'b000};
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = too_wide || ((reqAddr & lo_mask) != '0);
`else
   assign trap = 1'b0;
`endif

   load_data_aligner #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_aligner (
      .rdata_i (memRData),
      .offset_i(off_q),
      .funct3_i(funct3_q),
      .data_o  (load_data)
   );

   // Next-state logic: request capture, bus handshakes, MMIO shortcuts, flush.
   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      off_d       = off_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      resp_data_d = resp_data_q;
      fault_d     = fault_q;
      uart_d      = uart_q;
      uart_we_d   = 1'b0;
      reqReady    = (state_q == StIdle) && !flush;
      accept      = reqValid && reqReady;

      case (state_q)
         StIdle: begin
            if (accept) begin
               store_d     = reqStore;
               funct3_d    = reqFunct3;
               addr_d      = eff_addr & ~ADDR_WIDTH'(NumBytes - 1);
               off_d       = req_off;
               be_d        = reqStore ? (be_base << req_off) : '0;
               wdata_d     = reqStore ? req_wdata : '0;
               resp_data_d = '0;
               fault_d     = 1'b0;
               if (trap) begin
                  fault_d = 1'b1;
                  state_d = StResp;
               end else if (reqStore && (reqAddr == ADDR_WIDTH'(UART_ADDR))) begin
                  uart_we_d = 1'b1;
                  uart_d    = reqWData[7:0];
                  state_d   = StResp;
               end else if (!reqStore && (reqAddr == ADDR_WIDTH'(COUNTER_ADDR))) begin
                  resp_data_d = counter_q;
                  state_d     = StResp;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            if (flush) begin
               state_d = StIdle;
            end else if (memReqReady) begin
               state_d = store_q ? StResp : StWait;
            end
         end
         StWait: begin
            if (flush) begin
               // A response arriving with the flush is simply dropped
               state_d = memRespValid ? StIdle : StDrain;
            end else if (memRespValid) begin
               resp_data_d = load_data;
               state_d     = StResp;
            end
         end
         StDrain: begin
            if (memRespValid) begin
               state_d = StIdle;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Request/response state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         store_q     <= 1'b0;
         funct3_q    <= '0;
         addr_q      <= '0;
         off_q       <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         resp_data_q <= '0;
         fault_q     <= 1'b0;
         uart_q      <= '0;
         uart_we_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         store_q     <= store_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         off_q       <= off_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         resp_data_q <= resp_data_d;
         fault_q     <= fault_d;
         uart_q      <= uart_d;
         uart_we_q   <= uart_we_d;
      end
   end

   // Free-running cycle counter, wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         counter_q <= '0;
      end else begin
         counter_q <= counter_q + DATA_WIDTH'(1);
      end
   end

   assign respValid   = (state_q == StResp);
   assign respData    = respValid ? resp_data_q : '0;
   assign respFault   = respValid & fault_q;
   assign memReqValid = (state_q == StReq);
   assign memWe       = memReqValid & store_q;
   assign memAddr     = addr_q;
   assign memByteEn   = be_q;
   assign memWData    = wdata_q;
   assign uart        = uart_q;
   assign uartWe      = uart_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized traffic against a byte-addressed memory model.
module tb_load_store_unit;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam logic [31:0] UartA = 32'hF000_0000;
   localparam logic [31:0] CntA  = 32'hF000_0100;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          flush;
   logic          reqValid;
   logic          reqReady;
   logic          reqStore;
   logic [2:0]    reqFunct3;
   logic [AW-1:0] reqAddr;
   logic [DW-1:0] reqWData;
   logic          respValid;
   logic [DW-1:0] respData;
   logic          respFault;
   logic          memReqValid;
   logic          memReqReady;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [3:0]    memByteEn;
   logic [DW-1:0] memWData;
   logic          memRespValid;
   logic [DW-1:0] memRData;
   logic [7:0]    uart;
   logic          uartWe;

   int          checks;
   int          errors;
   int unsigned cyc;
   logic [7:0]  mem [logic [31:0]];

   load_store_unit #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .UART_ADDR   (UartA),
      .COUNTER_ADDR(CntA)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .reqValid    (reqValid),
      .reqReady    (reqReady),
      .reqStore    (reqStore),
      .reqFunct3   (reqFunct3),
      .reqAddr     (reqAddr),
      .reqWData    (reqWData),
      .respValid   (respValid),
      .respData    (respData),
      .respFault   (respFault),
      .memReqValid (memReqValid),
      .memReqReady (memReqReady),
      .memWe       (memWe),
      .memAddr     (memAddr),
      .memByteEn   (memByteEn),
      .memWData    (memWData),
      .memRespValid(memRespValid),
      .memRData    (memRData),
      .uart        (uart),
      .uartWe      (uartWe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // One clock; cyc tracks the DUT cycle counter value after reset release.
   task automatic step();
      @(posedge clk);
      cyc++;
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'((a * 32'd29) ^ 32'h5A);
   endfunction

   task automatic wait_ready(input string tag);
      int unsigned w;
      w = 0;
      while (!reqReady && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) check({tag, "/ready_timeout"}, 64'(reqReady), 64'd1);
   endtask

   task automatic accept_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd);
      reqValid  = 1'b1;
      reqStore  = st;
      reqFunct3 = f3;
      reqAddr   = addr;
      reqWData  = wd;
      step();
      reqValid  = 1'b0;
      reqStore  = 1'b0;
      reqFunct3 = '0;
      reqAddr   = '0;
      reqWData  = '0;
   endtask

   // Full transaction against the memory model; bus timing driven by stall/lat.
   task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int unsigned stall, input int unsigned lat,
                      input string tag);
      int unsigned n, off;
      bit          uns, wide, mis, trap_path, uart_path, cnt_path, early;
      logic [31:0] eff, wa, exp_wd, rdata, exp_cnt;
      logic [3:0]  exp_be;
      logic [63:0] v;
      n         = 1 << f3[1:0];
      uns       = f3[2];
      wide      = (f3[1:0] == 2'd3) || (f3 == 3'b110);
      if (wide) n = 4;
      mis       = wide || ((addr % n) != 0);
      eff       = addr - (addr % n);
      wa        = eff - (eff % 4);
      off       = eff % 4;
      trap_path = TrapEn && mis;
      uart_path = !trap_path && st && (addr == UartA);
      cnt_path  = !trap_path && !st && (addr == CntA);
      exp_be    = '0;
      exp_wd    = '0;
      v         = '0;
      rdata     = '0;
      for (int i = 0; i < int'(n); i++) begin
         exp_be[off + i]          = 1'b1;
         exp_wd[8*(off + i) +: 8] = wd[8*i +: 8];
         v[8*i +: 8]              = rd(eff + 32'(i));
      end
      if (!uns && v[8*n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      for (int i = 0; i < 4; i++) rdata[8*i +: 8] = rd(wa + 32'(i));

      wait_ready(tag);
      exp_cnt = cyc;
      accept_req(st, f3, addr, wd);

      if (trap_path || uart_path || cnt_path) begin
         check({tag, "/memReqValid"}, 64'(memReqValid), 64'd0);
         check({tag, "/respValid"}, 64'(respValid), 64'd1);
         check({tag, "/respFault"}, 64'(respFault), 64'(trap_path));
         check({tag, "/respData"}, 64'(respData), cnt_path ? 64'(exp_cnt) : 64'd0);
         check({tag, "/uartWe"}, 64'(uartWe), 64'(uart_path));
         if (uart_path) check({tag, "/uart"}, 64'(uart), 64'(wd[7:0]));
         step();
         check({tag, "/respValid_off"}, 64'(respValid), 64'd0);
         check({tag, "/memReqValid_off"}, 64'(memReqValid), 64'd0);
      end else begin
         check({tag, "/memReqValid"}, 64'(memReqValid), 64'd1);
         check({tag, "/memAddr"}, 64'(memAddr), 64'(wa));
         check({tag, "/memWe"}, 64'(memWe), 64'(st));
         if (st) begin
            check({tag, "/memByteEn"}, 64'(memByteEn), 64'(exp_be));
            check({tag, "/memWData"}, 64'(memWData), 64'(exp_wd));
         end
         for (int s = 0; s < int'(stall); s++) step();
         if (stall > 0) check({tag, "/memReqValid_held"}, 64'(memReqValid), 64'd1);
         memReqReady = 1'b1;
         step();
         memReqReady = 1'b0;
         if (st) begin
            for (int i = 0; i < int'(n); i++) mem[eff + 32'(i)] = wd[8*i +: 8];
         end else begin
            early = 1'b0;
            for (int j = 0; j < int'(lat) - 1; j++) begin
               early |= respValid;
               step();
            end
            memRespValid = 1'b1;
            memRData     = rdata;
            early |= respValid;
            check({tag, "/early_resp"}, 64'(early), 64'd0);
            step();
            memRespValid = 1'b0;
            memRData     = $urandom;
         end
         check({tag, "/respValid"}, 64'(respValid), 64'd1);
         check({tag, "/respFault"}, 64'(respFault), 64'd0);
         check({tag, "/respData"}, 64'(respData), st ? 64'd0 : 64'(v[31:0]));
         step();
         check({tag, "/respValid_off"}, 64'(respValid), 64'd0);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      cyc          = 0;
      rst          = 1'b0;
      flush        = 1'b0;
      reqValid     = 1'b0;
      reqStore     = 1'b0;
      reqFunct3    = '0;
      reqAddr      = '0;
      reqWData     = '0;
      memReqReady  = 1'b0;
      memRespValid = 1'b0;
      memRData     = '0;

      // Reset state
      step();
      step();
      check("rst/respValid", 64'(respValid), 64'd0);
      check("rst/memReqValid", 64'(memReqValid), 64'd0);
      check("rst/uartWe", 64'(uartWe), 64'd0);
      check("rst/memByteEn", 64'(memByteEn), 64'd0);
      check("rst/memAddr", 64'(memAddr), 64'd0);
      rst = 1'b1;
      cyc = 0;
      #1;
      check("rst/reqReady", 64'(reqReady), 64'd1);

      // LB sign extension with 3-cycle bus latency
      mem[32'h100] = 8'h00;
      mem[32'h101] = 8'h00;
      mem[32'h102] = 8'hFF;
      mem[32'h103] = 8'h80;
      txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 3, "lb_103");

      // SH to upper half, then UART byte store
      txn(1'b1, 3'b001, 32'h102, 32'hABCD, 0, 1, "sh_102");
      txn(1'b1, 3'b000, UartA, 32'h41, 0, 1, "sb_uart");

      // Misaligned LW: fault with trap build, aligned-down bus access otherwise
      txn(1'b0, 3'b010, 32'h101, 32'h0, 1, 2, "lw_101");
      if (TrapEn) txn(1'b0, 3'b011, 32'h108, 32'h0, 0, 1, "ld_32");

      // Cycle counter read after some idle time
      for (int i = 0; i < 7; i++) step();
      txn(1'b0, 3'b010, CntA, 32'h0, 0, 1, "cnt_a");

      // Flush in WAIT, late response is drained
      wait_ready("fl_wait");
      accept_req(1'b0, 3'b010, 32'h300, 32'h0);
      check("fl_wait/memReqValid", 64'(memReqValid), 64'd1);
      memReqReady = 1'b1;
      step();
      memReqReady = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check("fl_wait/drain_ready", 64'(reqReady), 64'd0);
      check("fl_wait/resp0", 64'(respValid), 64'd0);
      step();
      memRespValid = 1'b1;
      memRData     = 32'hDEAD_BEEF;
      check("fl_wait/resp1", 64'(respValid), 64'd0);
      step();
      memRespValid = 1'b0;
      #1;
      check("fl_wait/ready_back", 64'(reqReady), 64'd1);
      check("fl_wait/resp2", 64'(respValid), 64'd0);
      step();
      check("fl_wait/resp3", 64'(respValid), 64'd0);

      // Flush in REQ drops the request without a handshake
      accept_req(1'b1, 3'b010, 32'h304, 32'h1234_5678);
      flush = 1'b1;
      #1;
      check("fl_req/ready_low", 64'(reqReady), 64'd0);
      step();
      flush = 1'b0;
      #1;
      check("fl_req/ready_back", 64'(reqReady), 64'd1);
      check("fl_req/memReqValid", 64'(memReqValid), 64'd0);
      check("fl_req/respValid", 64'(respValid), 64'd0);
      step();
      check("fl_req/no_write", 64'(rd(32'h304)), 64'(8'((32'h304 * 32'd29) ^ 32'h5A)));

      // Flush coincident with the response
      accept_req(1'b0, 3'b000, 32'h308, 32'h0);
      memReqReady = 1'b1;
      step();
      memReqReady  = 1'b0;
      flush        = 1'b1;
      memRespValid = 1'b1;
      step();
      flush        = 1'b0;
      memRespValid = 1'b0;
      #1;
      check("fl_same/respValid", 64'(respValid), 64'd0);
      check("fl_same/ready", 64'(reqReady), 64'd1);

      // Reset mid-transaction, stale response afterwards is ignored
      step();
      accept_req(1'b0, 3'b010, 32'h30C, 32'h0);
      memReqReady = 1'b1;
      step();
      memReqReady = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_mid/memReqValid", 64'(memReqValid), 64'd0);
      check("rst_mid/respValid", 64'(respValid), 64'd0);
      step();
      rst = 1'b1;
      cyc = 0;
      memRespValid = 1'b1;
      step();
      memRespValid = 1'b0;
      check("rst_mid/stale", 64'(respValid), 64'd0);
      #1;
      check("rst_mid/ready", 64'(reqReady), 64'd1);
      txn(1'b0, 3'b010, CntA, 32'h0, 0, 1, "cnt_after_rst");

      // Randomized traffic in a small window so loads see earlier stores
      for (int t = 0; t < 80; t++) begin
         bit          st;
         logic [2:0]  f3;
         logic [31:0] a;
         int unsigned pick;
         st   = 1'($urandom_range(0, 1));
         pick = $urandom_range(0, 4);
         if (st) f3 = 3'(pick % 3);
         else    f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
         if (TrapEn && ($urandom_range(0, 7) == 0)) f3 = st ? 3'b011 : 3'b110;
         a = 32'h200 + $urandom_range(0, 31);
         pick = $urandom_range(0, 19);
         if (pick == 0) begin
            st = 1'b0;
            f3 = 3'b010;
            a  = CntA;
         end else if (pick == 1) begin
            st = 1'b1;
            f3 = 3'b000;
            a  = UartA;
         end
         txn(st, f3, a, $urandom, $urandom_range(0, 2), $urandom_range(1, 4),
             $sformatf("rnd%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit
Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data path width, 32 or 64 only.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter UART_ADDR, default 32'hF000_0000, MMIO UART transmit register byte address.
REQ-004 SHALL have parameter COUNTER_ADDR, default 32'hF000_0100, MMIO cycle-counter read address.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port flush  input  1  squash the in-flight and incoming request.
REQ-008 SHALL have port reqValid  input  1  pipeline request present.
REQ-009 SHALL have port reqReady  output  1  unit accepts a request this cycle.
REQ-010 SHALL have port reqStore  input  1  1=store, 0=load.
REQ-011 SHALL have port reqFunct3  input  3  RISC-V width code: B/H/W/D, BU/HU/WU.
REQ-012 SHALL have port reqAddr  input  ADDR_WIDTH  byte address.
REQ-013 SHALL have port reqWData  input  DATA_WIDTH  store data, right-justified.
REQ-014 SHALL have port respValid  output  1  one-cycle completion pulse.
REQ-015 SHALL have port respData  output  DATA_WIDTH  extended load data, 0 for stores.
REQ-016 SHALL have port respFault  output  1  misaligned-access fault, qualified by respValid.
REQ-017 SHALL have port memReqValid  output  1  bus request.
REQ-018 SHALL have port memReqReady  input  1  bus accepts request.
REQ-019 SHALL have port memWe  output  1  bus write.
REQ-020 SHALL have port memAddr  output  ADDR_WIDTH  address aligned to DATA_WIDTH/8.
REQ-021 SHALL have port memByteEn  output  DATA_WIDTH/8  write byte lanes.
REQ-022 SHALL have port memWData  output  DATA_WIDTH  lane-shifted store data.
REQ-023 SHALL have port memRespValid  input  1  read data returned, variable latency >=1 cycle.
REQ-024 SHALL have port memRData  input  DATA_WIDTH  full-width read data.
REQ-025 SHALL have ports uart output 8 and uartWe output 1, UART byte and one-cycle strobe.
Function
REQ-026 FSM states SHALL be IDLE, REQ, WAIT, DRAIN, RESP; reqReady=1 only in IDLE with flush=0.
REQ-027 Accept (reqValid&reqReady) SHALL register request; bus access goes IDLE->REQ; memReqValid held until memReqReady.
REQ-028 Store SHALL go REQ->RESP on memReqReady; load SHALL go REQ->WAIT, then WAIT->RESP on memRespValid.
REQ-029 RESP SHALL last one cycle, drive respValid=1, return to IDLE; load latency accept-to-respValid = bus latency + 2 cycles minimum.
REQ-030 Load data SHALL be shifted by addr low bits, zero-extended (xU) or sign-extended (B/H/W) to DATA_WIDTH, registered at RESP.
REQ-031 D/WU codes with DATA_WIDTH=32 SHALL be treated as misaligned (fault path).
REQ-032 Store to UART_ADDR SHALL skip the bus, pulse uartWe with uart=reqWData[7:0] in the cycle after accept, then RESP.
REQ-033 Load from COUNTER_ADDR SHALL skip the bus and return the free-running DATA_WIDTH cycle counter value sampled at accept; counter wraps to 0.
REQ-034 flush in REQ SHALL drop to IDLE without bus handshake; flush in WAIT SHALL go DRAIN, discard memRespValid, then IDLE; no respValid for flushed requests.
REQ-035 flush and memRespValid in the same WAIT cycle SHALL discard data and go IDLE.
Reset
REQ-036 On rst low SHALL enter IDLE, clear counter and all registers; outputs 0 except reqReady=1 after release.
REQ-037 Reset mid-transaction SHALL abandon it; a later stale memRespValid in IDLE SHALL be ignored.
Configuration
REQ-038 With LSU_MISALIGN_TRAP_EN defined, misaligned accesses SHALL skip the bus and complete via RESP with respFault=1.
REQ-039 Without LSU_MISALIGN_TRAP_EN, address SHALL be aligned down to access size, respFault tied 0.
Structure
REQ-040 LsuState enum, funct3 constants and MMIO address defaults SHALL live in package BasicTypes.
REQ-041 Load shift/extension SHALL be sub-module load_data_aligner (combinational, parameter DATA_WIDTH).
Verification
REQ-042 LB addr 0x103, memRData 0x80FF_0000 after 3 cycles -> respValid at accept+5, respData 0xFFFF_FF80.
REQ-043 SH addr 0x102 wdata 0xABCD -> memByteEn 4'b1100, memWData 0xABCD_0000, respValid after memReqReady.
REQ-044 SB to UART_ADDR wdata 0x41 -> uartWe pulse with uart 0x41, memReqValid never asserted.
REQ-045 LW addr 0x101 with LSU_MISALIGN_TRAP_EN -> respFault=1, no bus request; without macro -> memAddr 0x100.
REQ-046 flush during WAIT, memRespValid two cycles later -> no respValid, reqReady returns 1 next cycle.
